pc_fetch_unit: RTL and testbench
================================

# pc_fetch_unit

Owns the architectural PC register and the instruction-fetch handshake of the multi-cycle CPU. It presents the current PC (`cpc`) and fetched instruction (`ins`) to the next-PC logic, and loads that logic's `npc` result when the controller commands a PC write. It runs a request/acknowledge fetch against instruction memory, with a timeout and an alignment check.

## Interface
- `RESET_PC`, default 32'h0000_3000: PC value loaded on reset.
- `TIMEOUT`, default 16: max cycles in FETCH without `imem_ack` before abort; range 1..255.

- `clk`  in  1  system clock, all state on rising edge
- `reset`  in  1  synchronous, active-high reset
- `fetch_en`  in  1  controller requests fetch at `cpc`
- `pc_write`  in  1  controller commands `cpc <= npc`
- `npc`  in  32  next PC from next-PC logic
- `imem_ack`  in  1  instruction memory data valid this cycle
- `imem_rdata`  in  32  instruction word, valid with `imem_ack`
- `imem_req`  out  1  fetch request, held until ack or timeout
- `imem_addr`  out  32  fetch address, equals `cpc` while `imem_req`
- `cpc`  out  32  current PC
- `ins`  out  32  instruction register
- `ins_valid`  out  1  `ins` holds the word fetched from current `cpc`
- `addr_err`  out  1  one-cycle pulse: misaligned `npc` rejected
- `bus_err`  out  1  sticky: fetch timed out
- `ins_count`  out  32  count of completed fetches, wraps

## Operation
- Reset values: `cpc`=`RESET_PC`, `ins`=0, `ins_valid`=0, `imem_req`=0, `addr_err`=0, `bus_err`=0, `ins_count`=0. State is IDLE and the timer is 0.
- States: IDLE, FETCH, VALID.
- IDLE:
  - `fetch_en` -> FETCH.
  - `pc_write` with aligned `npc` loads `cpc`.
  - If `pc_write` and `fetch_en` occur together, the fetch uses the new `cpc`.
- FETCH:
  - `imem_req`=1 and `imem_addr`=`cpc`.
  - On `imem_ack`: `ins`<=`imem_rdata`, `ins_valid`<=1, `ins_count`+1 (mod 2^32), timer cleared, -> VALID.
  - Otherwise the timer increments. When the timer reaches `TIMEOUT`: `bus_err`<=1, timer cleared, -> IDLE, `ins` unchanged.
  - `pc_write` and `fetch_en` are ignored.
- VALID:
  - `pc_write` with aligned `npc`: `cpc`<=`npc`, `ins_valid`<=0, -> IDLE. With `fetch_en` in the same cycle -> FETCH instead, using the new `cpc`.
  - `fetch_en` alone is ignored; there is no refetch of a valid word.
- Alignment: `npc[1:0]`!=0 on `pc_write` (IDLE/VALID) means `cpc`, state and `ins_valid` are unchanged and `addr_err` pulses for 1 cycle. An accompanying `fetch_en` still takes effect in IDLE, using the old `cpc`.
- `bus_err` clears only on `reset`. Fetching continues normally after a timeout.
- `reset` overrides everything, including mid-FETCH. `imem_req` drops the next cycle, and a late `imem_ack` after reset is ignored (state IDLE).

## Timing
- `fetch_en` sampled in IDLE at edge t -> `imem_req`=1 after edge t.
- `imem_ack` sampled at edge k -> `ins`/`ins_valid` updated after edge k, and `imem_req`=0 after edge k.
- Zero-wait memory (ack in the first FETCH cycle) gives 2 cycles from `fetch_en` to `ins_valid`.
- `pc_write` -> `cpc` updated after the same edge. `cpc` is stable at all other times.
- Timeout: with no ack, `imem_req` stays high for exactly `TIMEOUT` cycles. `bus_err` rises after the `TIMEOUT`th FETCH edge.
- `imem_ack` in the cycle the timer would expire counts as success; ack wins.
- `imem_ack` outside FETCH is ignored.

## Structure
- Shared package `cpu_pkg` holds:
  - fetch state enum (IDLE/FETCH/VALID);
  - `RESET_PC` default constant 32'h0000_3000;
  - `WORD_ALIGN_MASK`=2'b11.
- One sub-module, `fetch_timer`: 8-bit counter with clear/enable inputs and an `expired` output compared against `TIMEOUT`.
- FSM, PC and instruction registers live in the top level.

## Test plan
- Reset, then `fetch_en`, with ack on the first FETCH cycle and `imem_rdata`=32'h2008_0005 -> `imem_addr`=32'h0000_3000, `ins`=32'h2008_0005, `ins_valid`=1 two cycles after `fetch_en`, `ins_count`=1.
- In VALID, `pc_write` + `fetch_en` with `npc`=32'h0000_3004 -> `cpc`=32'h0000_3004, `ins_valid`=0, `imem_addr`=32'h0000_3004 on the next cycle.
- `pc_write` with `npc`=32'h0000_3006 in VALID -> `cpc` stays 32'h0000_3000, `ins_valid` stays 1, `addr_err` high for exactly 1 cycle.
- `TIMEOUT`=4 with no ack -> `imem_req` high for 4 cycles, then `bus_err`=1 and state IDLE. A following fetch with ack succeeds while `bus_err` stays 1.
- Ack arriving on the 4th cycle with `TIMEOUT`=4 -> success, `bus_err`=0. `reset` asserted mid-FETCH with ack next cycle -> `ins`=0, `ins_valid`=0, `cpc`=32'h0000_3000.
- Preload `ins_count`=32'hFFFF_FFFF via 2^32-1 fetches (or force), then one more fetch -> `ins_count`=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared fetch-state type, reset PC and alignment helpers
// Purpose: definitions shared by the PC/fetch unit and its timer.
// Contents: fetch_state_t (IDLE/FETCH/VALID), RESET_PC_DEFAULT,
//           WORD_ALIGN_MASK, is_word_aligned().
package cpu_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_VALID = 2'd2
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam logic [1:0]  WORD_ALIGN_MASK  = 2'b11;

    // Only the two low address bits matter for word alignment.
    function automatic logic is_word_aligned(input logic [1:0] addr_lo);
        return (addr_lo & WORD_ALIGN_MASK) == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_timer.sv
// rtl/fetch_timer.sv - 8-bit fetch timeout counter
// Purpose: counts FETCH cycles without an acknowledge.
// Ports:
//   clk     in   clock
//   reset   in   synchronous active-high reset
//   clear   in   force the count back to 0
//   enable  in   count one more waiting cycle
//   expired out  this enabled cycle brings the count to TIMEOUT
module fetch_timer #(
    parameter logic [7:0] TIMEOUT = 8'd16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [7:0] count_q;

    // Flagged on the cycle whose increment would reach TIMEOUT, so the
    // request is held for exactly TIMEOUT cycles before the abort.
    assign expired = enable && ((count_q + 8'd1) == TIMEOUT);

    always_ff @(posedge clk) begin
        if (reset || clear || expired) begin
            count_q <= 8'd0;
        end else if (enable) begin
            count_q <= count_q + 8'd1;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - architectural PC register and instruction fetch handshake
// Purpose: holds the PC, fetches the instruction at it with a timeout,
//          and loads the next PC on command after an alignment check.
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   fetch_en, pc_write   controller commands
//   npc                  next PC candidate
//   imem_ack, imem_rdata instruction memory response
//   imem_req, imem_addr  instruction memory request
//   cpc, ins, ins_valid  current PC, instruction register and its validity
//   addr_err             one-cycle pulse when a misaligned npc is rejected
//   bus_err              sticky fetch-timeout flag
//   ins_count            completed fetch count, wraps
module pc_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [7:0]  TIMEOUT  = 8'd16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_en,
    input  logic        pc_write,
    input  logic [31:0] npc,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] cpc,
    output logic [31:0] ins,
    output logic        ins_valid,
    output logic        addr_err,
    output logic        bus_err,
    output logic [31:0] ins_count
);

    fetch_state_t state_q, state_d;
    logic [31:0]  cpc_d, ins_d, ins_count_d;
    logic         bus_err_d, addr_err_d;
    logic         npc_aligned, in_fetch;
    logic         timer_enable, timer_expired;

    assign npc_aligned  = is_word_aligned(npc[1:0]);
    assign in_fetch     = (state_q == S_FETCH);
    assign timer_enable = in_fetch && !imem_ack;

    assign imem_req  = in_fetch;
    assign imem_addr = cpc;
    assign ins_valid = (state_q == S_VALID);

    fetch_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (!timer_enable),
        .enable (timer_enable),
        .expired(timer_expired)
    );

    always_comb begin
        state_d     = state_q;
        cpc_d       = cpc;
        ins_d       = ins;
        ins_count_d = ins_count;
        bus_err_d   = bus_err;
        addr_err_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pc_write) begin
                    if (npc_aligned) cpc_d = npc;
                    else             addr_err_d = 1'b1;
                end
                // imem_addr follows cpc, so a same-cycle PC load is what
                // gets fetched.
                if (fetch_en) state_d = S_FETCH;
            end
            S_FETCH: begin
                // Ack wins over a timeout expiring in the same cycle.
                if (imem_ack) begin
                    ins_d       = imem_rdata;
                    ins_count_d = ins_count + 32'd1;
                    state_d     = S_VALID;
                end else if (timer_expired) begin
                    bus_err_d = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_VALID: begin
                if (pc_write) begin
                    if (npc_aligned) begin
                        cpc_d   = npc;
                        state_d = fetch_en ? S_FETCH : S_IDLE;
                    end else begin
                        addr_err_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cpc       <= RESET_PC;
            ins       <= 32'd0;
            ins_count <= 32'd0;
            bus_err   <= 1'b0;
            addr_err  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cpc       <= cpc_d;
            ins       <= ins_d;
            ins_count <= ins_count_d;
            bus_err   <= bus_err_d;
            addr_err  <= addr_err_d;
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - self-checking bench for pc_fetch_unit
module tb_pc_fetch_unit;

    localparam logic [7:0]  TO  = 8'd4;
    localparam logic [31:0] RPC = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        reset, fetch_en, pc_write, imem_ack;
    logic [31:0] npc, imem_rdata;
    logic        imem_req, ins_valid, addr_err, bus_err;
    logic [31:0] imem_addr, cpc, ins, ins_count;

    int errors = 0;
    int checks = 0;

    // Transaction-level reference model of the architectural state.
    logic [31:0] m_cpc, m_ins, m_count;
    logic        m_valid, m_bus_err;

    pc_fetch_unit #(
        .RESET_PC(RPC),
        .TIMEOUT (TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .fetch_en  (fetch_en),
        .pc_write  (pc_write),
        .npc       (npc),
        .imem_ack  (imem_ack),
        .imem_rdata(imem_rdata),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .cpc       (cpc),
        .ins       (ins),
        .ins_valid (ins_valid),
        .addr_err  (addr_err),
        .bus_err   (bus_err),
        .ins_count (ins_count)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1; fetch_en = 1'b0; pc_write = 1'b0; imem_ack = 1'b0;
        npc = 32'd0; imem_rdata = 32'd0;
        tick(); tick();
        reset = 1'b0;
        m_cpc = RPC; m_ins = 32'd0; m_count = 32'd0; m_valid = 1'b0; m_bus_err = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (cpc !== RPC) begin errors++; $display("FAIL reset_cpc: got %h want %h", cpc, RPC); end
        checks++; if (ins !== 32'd0) begin errors++; $display("FAIL reset_ins: got %h want 0", ins); end
        checks++; if (ins_valid !== 1'b0) begin errors++; $display("FAIL reset_ins_valid: got %b want 0", ins_valid); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_imem_req: got %b want 0", imem_req); end
        checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL reset_addr_err: got %b want 0", addr_err); end
        checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL reset_bus_err: got %b want 0", bus_err); end
        checks++; if (ins_count !== 32'd0) begin errors++; $display("FAIL reset_ins_count: got %h want 0", ins_count); end
    endtask

    task automatic test_basic_fetch();
        fetch_en = 1'b1; tick(); fetch_en = 1'b0;
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL basic_req: got %b want 1", imem_req); end
        checks++; if (imem_addr !== RPC) begin errors++; $display("FAIL basic_addr: got %h want %h", imem_addr, RPC); end
        checks++; if (ins_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b want 0", ins_valid); end
        imem_ack = 1'b1; imem_rdata = 32'h2008_0005; tick(); imem_ack = 1'b0;
        m_ins = 32'h2008_0005; m_valid = 1'b1; m_count = 32'd1;
        checks++; if (ins !== m_ins) begin errors++; $display("FAIL basic_ins: got %h want %h", ins, m_ins); end
        checks++; if (ins_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", ins_valid); end
        checks++; if (ins_count !== 32'd1) begin errors++; $display("FAIL basic_count: got %h want 1", ins_count); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL basic_req_drop: got %b want 0", imem_req); end
    endtask

    task automatic test_misaligned();
        pc_write = 1'b1; npc = 32'h0000_3006; tick(); pc_write = 1'b0;
        checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL misalign_pulse: got %b want 1", addr_err); end
        checks++; if (cpc !== RPC) begin errors++; $display("FAIL misalign_cpc: got %h want %h", cpc, RPC); end
        checks++; if (ins_valid !== 1'b1) begin errors++; $display("FAIL misalign_valid: got %b want 1", ins_valid); end
        tick();
        checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL misalign_pulse_end: got %b want 0", addr_err); end
    endtask

    task automatic test_write_and_fetch();
        logic [31:0] w;
        fetch_en = 1'b1; tick(); fetch_en = 1'b0;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL valid_refetch: got req %b want 0", imem_req); end
        pc_write = 1'b1; fetch_en = 1'b1; npc = 32'h0000_3004; tick();
        pc_write = 1'b0; fetch_en = 1'b0;
        m_cpc = 32'h0000_3004;
        checks++; if (cpc !== m_cpc) begin errors++; $display("FAIL wf_cpc: got %h want %h", cpc, m_cpc); end
        checks++; if (ins_valid !== 1'b0) begin errors++; $display("FAIL wf_valid: got %b want 0", ins_valid); end
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL wf_req: got %b want 1", imem_req); end
        checks++; if (imem_addr !== m_cpc) begin errors++; $display("FAIL wf_addr: got %h want %h", imem_addr, m_cpc); end
        w = $urandom;
        imem_ack = 1'b1; imem_rdata = w; tick(); imem_ack = 1'b0;
        m_ins = w; m_count = m_count + 32'd1; m_valid = 1'b1;
        checks++; if (ins !== m_ins) begin errors++; $display("FAIL wf_ins: got %h want %h", ins, m_ins); end
        checks++; if (ins_count !== m_count) begin errors++; $display("FAIL wf_count: got %h want %h", ins_count, m_count); end
    endtask

    task automatic test_timeout();
        int n;
        logic [31:0] w;
        pc_write = 1'b1; npc = 32'h0000_3008; tick(); pc_write = 1'b0;
        m_cpc = 32'h0000_3008; m_valid = 1'b0;
        checks++; if (ins_valid !== 1'b0) begin errors++; $display("FAIL to_leave_valid: got %b want 0", ins_valid); end
        fetch_en = 1'b1; tick(); fetch_en = 1'b0;
        n = 0;
        while (imem_req === 1'b1 && n < 20) begin n++; tick(); end
        m_bus_err = 1'b1;
        checks++; if (n !== int'(TO)) begin errors++; $display("FAIL to_req_cycles: got %0d want %0d", n, TO); end
        checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL to_bus_err: got %b want 1", bus_err); end
        checks++; if (ins !== m_ins) begin errors++; $display("FAIL to_ins_kept: got %h want %h", ins, m_ins); end
        checks++; if (ins_valid !== 1'b0) begin errors++; $display("FAIL to_valid: got %b want 0", ins_valid); end
        checks++; if (ins_count !== m_count) begin errors++; $display("FAIL to_count: got %h want %h", ins_count, m_count); end
        w = $urandom;
        fetch_en = 1'b1; tick(); fetch_en = 1'b0;
        imem_ack = 1'b1; imem_rdata = w; tick(); imem_ack = 1'b0;
        m_ins = w; m_valid = 1'b1; m_count = m_count + 32'd1;
        checks++; if (ins !== m_ins) begin errors++; $display("FAIL to_refetch_ins: got %h want %h", ins, m_ins); end
        checks++; if (ins_valid !== 1'b1) begin errors++; $display("FAIL to_refetch_valid: got %b want 1", ins_valid); end
        checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b want 1", bus_err); end
    endtask

    task automatic test_ack_last_cycle();
        do_reset();
        fetch_en = 1'b1; tick(); fetch_en = 1'b0;
        repeat (int'(TO) - 1) tick();
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL last_req_held: got %b want 1", imem_req); end
        imem_ack = 1'b1; imem_rdata = 32'hCAFE_0001; tick(); imem_ack = 1'b0;
        checks++; if (ins_valid !== 1'b1) begin errors++; $display("FAIL last_valid: got %b want 1", ins_valid); end
        checks++; if (ins !== 32'hCAFE_0001) begin errors++; $display("FAIL last_ins: got %h want cafe0001", ins); end
        checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL last_bus_err: got %b want 0", bus_err); end
        checks++; if (ins_count !== 32'd1) begin errors++; $display("FAIL last_count: got %h want 1", ins_count); end
    endtask

    task automatic test_reset_mid_fetch();
        do_reset();
        fetch_en = 1'b1; tick(); fetch_en = 1'b0;
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rmf_req: got %b want 1", imem_req); end
        reset = 1'b1; tick(); reset = 1'b0;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rmf_req_drop: got %b want 0", imem_req); end
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; tick(); imem_ack = 1'b0;
        checks++; if (ins !== 32'd0) begin errors++; $display("FAIL rmf_ins: got %h want 0", ins); end
        checks++; if (ins_valid !== 1'b0) begin errors++; $display("FAIL rmf_valid: got %b want 0", ins_valid); end
        checks++; if (cpc !== RPC) begin errors++; $display("FAIL rmf_cpc: got %h want %h", cpc, RPC); end
        checks++; if (ins_count !== 32'd0) begin errors++; $display("FAIL rmf_count: got %h want 0", ins_count); end
    endtask

    task automatic test_count_wrap();
        do_reset();
        force dut.ins_count = 32'hFFFF_FFFF;
        #1;
        release dut.ins_count;
        checks++; if (ins_count !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_preload: got %h want ffffffff", ins_count); end
        @(negedge clk);
        fetch_en = 1'b1; tick(); fetch_en = 1'b0;
        imem_ack = 1'b1; imem_rdata = 32'h1234_5678; tick(); imem_ack = 1'b0;
        checks++; if (ins_count !== 32'd0) begin errors++; $display("FAIL wrap_count: got %h want 0", ins_count); end
    endtask

    task automatic test_random();
        logic        pw, fe, aligned, start, exp_aerr;
        logic [31:0] nv, w;
        int          lat, n;
        do_reset();
        for (int it = 0; it < 60; it++) begin
            pw = 1'($urandom_range(0, 1));
            fe = 1'($urandom_range(0, 1));
            nv = RPC + ($urandom_range(0, 255) << 2);
            if ($urandom_range(0, 3) == 0) nv = nv + $urandom_range(1, 3);
            aligned = (nv % 4) == 0;
            pc_write = pw; fetch_en = fe; npc = nv;
            imem_ack = 1'($urandom_range(0, 1)); imem_rdata = $urandom;
            tick();
            pc_write = 1'b0; fetch_en = 1'b0; imem_ack = 1'b0;
            exp_aerr = pw && !aligned;
            if (m_valid) begin
                start = 1'b0;
                if (pw && aligned) begin m_cpc = nv; m_valid = 1'b0; start = fe; end
            end else begin
                if (pw && aligned) m_cpc = nv;
                start = fe;
            end
            checks++; if (cpc !== m_cpc) begin errors++; $display("FAIL rnd_cpc it%0d: got %h want %h", it, cpc, m_cpc); end
            checks++; if (addr_err !== exp_aerr) begin errors++; $display("FAIL rnd_addr_err it%0d: got %b want %b", it, addr_err, exp_aerr); end
            checks++; if (imem_req !== start) begin errors++; $display("FAIL rnd_req it%0d: got %b want %b", it, imem_req, start); end
            checks++; if (ins_valid !== m_valid) begin errors++; $display("FAIL rnd_valid it%0d: got %b want %b", it, ins_valid, m_valid); end
            if (start) begin
                checks++; if (imem_addr !== m_cpc) begin errors++; $display("FAIL rnd_addr it%0d: got %h want %h", it, imem_addr, m_cpc); end
                lat = $urandom_range(0, 5);
                if (lat < int'(TO)) begin
                    repeat (lat) tick();
                    w = $urandom;
                    imem_ack = 1'b1; imem_rdata = w; tick(); imem_ack = 1'b0;
                    m_ins = w; m_valid = 1'b1; m_count = m_count + 32'd1;
                end else begin
                    n = 0;
                    while (imem_req === 1'b1 && n < 20) begin n++; tick(); end
                    m_bus_err = 1'b1;
                    checks++; if (n !== int'(TO)) begin errors++; $display("FAIL rnd_to_cycles it%0d: got %0d want %0d", it, n, TO); end
                end
                checks++; if (ins !== m_ins) begin errors++; $display("FAIL rnd_ins it%0d: got %h want %h", it, ins, m_ins); end
                checks++; if (ins_valid !== m_valid) begin errors++; $display("FAIL rnd_fvalid it%0d: got %b want %b", it, ins_valid, m_valid); end
                checks++; if (ins_count !== m_count) begin errors++; $display("FAIL rnd_count it%0d: got %h want %h", it, ins_count, m_count); end
                checks++; if (bus_err !== m_bus_err) begin errors++; $display("FAIL rnd_bus_err it%0d: got %b want %b", it, bus_err, m_bus_err); end
            end
        end
    endtask

    initial begin
        reset = 1'b1; fetch_en = 1'b0; pc_write = 1'b0; imem_ack = 1'b0;
        npc = 32'd0; imem_rdata = 32'd0;
        @(negedge clk);
        test_reset();
        test_basic_fetch();
        test_misaligned();
        test_write_and_fetch();
        test_timeout();
        test_ack_last_cycle();
        test_reset_mid_fetch();
        test_count_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
